// File: rtl/full_logic_drain_pkg.sv
// Shared types and constants for the D0/D1 receive-side drain.
package full_logic_pkg;
   localparam int   DATA_WIDTH = 6;
   localparam int   DEST_BIT   = DATA_WIDTH - 2;
   localparam logic SRC_D0     = 1'b0;
   localparam logic SRC_D1     = 1'b1;

   typedef enum logic [2:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR} state_t;

   // A programmed weight of zero still grants one pop per turn.
   function automatic logic [3:0] eff_weight(input logic [3:0] w);
      return (w == 4'd0) ? 4'd1 : w;
   endfunction
endpackage

// File: rtl/full_logic_drain_out_buf.sv
// Two-entry first-in-first-out holding {src, data} words on their way downstream.
module drain_out_buf #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);
   logic [1:0][W-1:0] mem;
   logic              wr_ptr, rd_ptr;
   logic              do_push, do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         mem    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end
endmodule

// File: rtl/full_logic_drain.sv
// Drains the D0/D1 FIFOs with weighted round-robin pops, checks destination bits and
// merges the words into one tagged valid/ready stream.
module full_logic_drain
   import full_logic_pkg::*;
#(
   parameter int data_width = 6,
   parameter int cnt_width  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  init,
   input  logic [3:0]            weight_D0,
   input  logic [3:0]            weight_D1,
   input  logic                  empty_D0,
   input  logic                  empty_D1,
   input  logic [data_width-1:0] data_D0,
   input  logic [data_width-1:0] data_D1,
   output logic                  D0_pop,
   output logic                  D1_pop,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [data_width-1:0] out_data,
   output logic                  out_src,
   output logic [cnt_width-1:0]  count_D0,
   output logic [cnt_width-1:0]  count_D1,
   output logic                  error_out,
   output logic                  active_out,
   output logic                  idle_out
);
   localparam int DBIT = data_width - 2;

   state_t                state;
   logic [3:0]            wgt0, wgt1, run_cnt, nxt_run, cur_w;
   logic                  turn, nxt_turn, in_flight, fl_src;
   logic                  pop_any, pop_sel, pop_en, cur_empty, oth_empty;
   logic                  hs, cap_mis, buf_full, buf_empty, buf_push;
   logic [1:0]            buf_cnt;
   logic [2:0]            free_eff;
   logic [data_width-1:0] cap_data;
   logic [data_width:0]   buf_head;

   assign hs       = out_valid && out_ready;
   assign cap_data = (fl_src == SRC_D1) ? data_D1 : data_D0;
   assign cap_mis  = in_flight && (cap_data[DBIT] != fl_src);
   assign buf_push = in_flight && (!buf_full || hs);

   // A slot freed by this cycle's handshake counts, which keeps 1 word/cycle with out_ready=1.
   assign free_eff = 3'd2 - {1'b0, buf_cnt} + {2'b00, hs};
   assign pop_en   = !reset && !init && !cap_mis
                     && (state == ST_IDLE || state == ST_ACTIVE)
                     && (free_eff > {2'b00, in_flight});

   always_comb begin
      cur_empty = (turn == SRC_D1) ? empty_D1 : empty_D0;
      oth_empty = (turn == SRC_D1) ? empty_D0 : empty_D1;
      cur_w     = (turn == SRC_D1) ? wgt1 : wgt0;
      pop_any   = 1'b0;
      pop_sel   = turn;
      nxt_turn  = turn;
      nxt_run   = run_cnt;
      if (pop_en) begin
         if (!cur_empty && run_cnt != cur_w) begin
            pop_any = 1'b1;
            nxt_run = run_cnt + 4'd1;
         end else if (!oth_empty) begin
            pop_any  = 1'b1;
            pop_sel  = ~turn;
            nxt_turn = ~turn;
            nxt_run  = 4'd1;
         end else if (!cur_empty) begin
            pop_any = 1'b1;
            nxt_run = 4'd1;
         end else begin
            nxt_run = 4'd0;
         end
      end
   end

   assign D0_pop = pop_any && (pop_sel == SRC_D0);
   assign D1_pop = pop_any && (pop_sel == SRC_D1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_RESET;
         wgt0      <= 4'd1;
         wgt1      <= 4'd1;
         turn      <= SRC_D0;
         run_cnt   <= 4'd0;
         in_flight <= 1'b0;
         fl_src    <= SRC_D0;
         count_D0  <= '0;
         count_D1  <= '0;
         error_out <= 1'b0;
      end else begin
         in_flight <= pop_any;
         fl_src    <= pop_sel;
         turn      <= nxt_turn;
         run_cnt   <= nxt_run;
         if (in_flight && fl_src == SRC_D0) count_D0 <= count_D0 + cnt_width'(1);
         if (in_flight && fl_src == SRC_D1) count_D1 <= count_D1 + cnt_width'(1);
         if (cap_mis) error_out <= 1'b1;
         case (state)
            ST_RESET: state <= ST_INIT;
            ST_INIT: begin
               wgt0    <= eff_weight(weight_D0);
               wgt1    <= eff_weight(weight_D1);
               turn    <= SRC_D0;
               run_cnt <= 4'd0;
               if (!init) state <= ST_IDLE;
            end
            ST_IDLE, ST_ACTIVE: begin
               if (cap_mis)
                  state <= ST_ERROR;
               else if (init) begin
                  if (!in_flight && buf_empty) state <= ST_INIT;
               end else if (state == ST_IDLE) begin
                  if (pop_any) state <= ST_ACTIVE;
               end else if (empty_D0 && empty_D1 && buf_empty && !in_flight)
                  state <= ST_IDLE;
            end
            ST_ERROR: state <= ST_ERROR;
            default:  state <= ST_RESET;
         endcase
      end
   end

   drain_out_buf #(.W(data_width + 1)) u_buf (
      .clk   (clk),
      .reset (reset),
      .push  (buf_push),
      .pop   (hs),
      .din   ({fl_src, cap_data}),
      .dout  (buf_head),
      .full  (buf_full),
      .empty (buf_empty),
      .count (buf_cnt)
   );

   assign out_valid  = !buf_empty;
   assign out_data   = buf_head[data_width-1:0];
   assign out_src    = buf_head[data_width];
   assign active_out = (state == ST_ACTIVE);
   assign idle_out   = (state == ST_IDLE);
endmodule

// File: tb/tb_full_logic_drain.sv
// Bench for full_logic_drain: FIFO models on both inputs, output monitor, WRR reference model.
module tb_full_logic_drain;
   logic       clk, reset, init, empty_D0, empty_D1, D0_pop, D1_pop;
   logic       out_valid, out_ready, out_src, error_out, active_out, idle_out;
   logic [3:0] weight_D0, weight_D1;
   logic [5:0] data_D0, data_D1, out_data;
   logic [4:0] count_D0, count_D1;

   full_logic_drain dut (
      .clk(clk), .reset(reset), .init(init), .weight_D0(weight_D0), .weight_D1(weight_D1),
      .empty_D0(empty_D0), .empty_D1(empty_D1), .data_D0(data_D0), .data_D1(data_D1),
      .D0_pop(D0_pop), .D1_pop(D1_pop), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_src(out_src), .count_D0(count_D0), .count_D1(count_D1),
      .error_out(error_out), .active_out(active_out), .idle_out(idle_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Source FIFO models: the stimulus process writes m*/wr*, the pop process owns rd*.
   logic [5:0] m0[256], m1[256];
   int         wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
   assign empty_D0 = (rd0 == wr0);
   assign empty_D1 = (rd1 == wr1);

   initial begin
      data_D0 = '0;
      data_D1 = '0;
   end

   always @(posedge clk) begin
      if (D0_pop && rd0 != wr0) begin
         data_D0 <= m0[rd0 & 255];
         rd0     <= rd0 + 1;
      end
      if (D1_pop && rd1 != wr1) begin
         data_D1 <= m1[rd1 & 255];
         rd1     <= rd1 + 1;
      end
   end

   logic [5:0] got_d[$];
   logic       got_s[$];
   int         pops0 = 0, pops1 = 0;
   bit         bad_pop = 1'b0;

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         got_d.push_back(out_data);
         got_s.push_back(out_src);
      end
      if (D0_pop) pops0 = pops0 + 1;
      if (D1_pop) pops1 = pops1 + 1;
      if ((D0_pop && empty_D0) || (D1_pop && empty_D1) || (D0_pop && D1_pop)) bad_pop = 1'b1;
   end

   int total = 0, bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic src, input logic [5:0] d);
      if (src) begin m1[wr1 & 255] = d; wr1++; end
      else     begin m0[wr0 & 255] = d; wr0++; end
   endtask

   task automatic do_reset_init(input logic [3:0] w0, input logic [3:0] w1);
      reset = 1'b1; init = 1'b0; out_ready = 1'b1;
      tick();
      wr0 = rd0; wr1 = rd1;
      repeat (2) tick();
      reset = 1'b0; init = 1'b1; weight_D0 = w0; weight_D1 = w1;
      repeat (2) tick();
      init = 1'b0;
      tick();
   endtask

   task automatic wait_idle(input string nm, input int budget, input bit rnd);
      int n = 0;
      bit done = 1'b0;
      while (!done && n < budget) begin
         if (rnd) out_ready = 1'($urandom);
         @(negedge clk);
         if (idle_out && !out_valid && empty_D0 && empty_D1) done = 1'b1;
         tick();
         n++;
      end
      out_ready = 1'b1;
      chk(nm, 32'(done), 32'd1);
   endtask

   // Word-level WRR reference: which source supplies each successive output word.
   logic exp_src[$];
   task automatic wrr_model(input int n0, input int n1, input logic [3:0] w0, input logic [3:0] w1);
      int rem[2];
      int w[2];
      int t = 0, run = 0;
      rem[0] = n0; rem[1] = n1;
      w[0] = (w0 == 0) ? 1 : int'(w0);
      w[1] = (w1 == 0) ? 1 : int'(w1);
      exp_src.delete();
      while (rem[0] + rem[1] > 0) begin
         if (rem[t] > 0 && run < w[t]) run++;
         else if (rem[1-t] > 0) begin t = 1 - t; run = 1; end
         else run = 1;
         exp_src.push_back(1'(t));
         rem[t]--;
      end
   endtask

   typedef struct {
      logic [3:0]  w0, w1;
      int          n0, n1, len;
      logic [15:0] pat;
   } vec_t;
   vec_t tbl[5];

   logic [5:0] e0[$], e1[$];
   logic [5:0] seq3[4];

   initial begin
      int base, pb0, pb1, nmis, i0, i1;
      logic [3:0] rw0, rw1;
      int rn0, rn1;
      logic [5:0] d;

      tbl[0] = '{w0: 4'd2, w1: 4'd1, n0: 2, n1: 2, len: 4, pat: 16'b1100};
      tbl[1] = '{w0: 4'd0, w1: 4'd0, n0: 3, n1: 3, len: 6, pat: 16'b101010};
      tbl[2] = '{w0: 4'd3, w1: 4'd1, n0: 4, n1: 2, len: 6, pat: 16'b101000};
      tbl[3] = '{w0: 4'd1, w1: 4'd2, n0: 1, n1: 4, len: 5, pat: 16'b11110};
      tbl[4] = '{w0: 4'd2, w1: 4'd2, n0: 0, n1: 3, len: 3, pat: 16'b111};
      seq3[0] = 6'b000011; seq3[1] = 6'b000100; seq3[2] = 6'b010001; seq3[3] = 6'b010010;

      // Reset and init sequence
      reset = 1'b1; init = 1'b0; out_ready = 1'b1; weight_D0 = 4'd0; weight_D1 = 4'd0;
      repeat (3) tick();
      chk("reset_outputs", 32'({D0_pop, D1_pop, out_valid, out_data, out_src, count_D0,
                                count_D1, error_out, active_out, idle_out}), 32'd0);
      reset = 1'b0; init = 1'b1; weight_D0 = 4'd2; weight_D1 = 4'd1;
      repeat (2) tick();
      chk("init_not_idle", 32'({idle_out, active_out}), 32'd0);
      init = 1'b0;
      tick();
      chk("idle_after_init", 32'(idle_out), 32'd1);
      chk("idle_outputs", 32'({D0_pop, D1_pop, out_valid, count_D0, count_D1, error_out,
                               active_out}), 32'd0);

      // Table: ordering under various weights, data integrity, counters
      foreach (tbl[c]) begin
         do_reset_init(tbl[c].w0, tbl[c].w1);
         for (int k = 0; k < tbl[c].n0; k++) load(1'b0, 6'(k + 3));
         for (int k = 0; k < tbl[c].n1; k++) load(1'b1, 6'h10 | 6'(k + 1));
         base = got_d.size();
         repeat (2) tick();
         wait_idle($sformatf("tbl%0d_drain", c), 200, 1'b0);
         chk($sformatf("tbl%0d_len", c), 32'(got_d.size() - base), 32'(tbl[c].len));
         i0 = 0; i1 = 0;
         for (int i = 0; i < tbl[c].len && base + i < got_d.size(); i++) begin
            chk($sformatf("tbl%0d_src%0d", c, i), 32'(got_s[base+i]), 32'(tbl[c].pat[i]));
            if (tbl[c].pat[i]) begin
               chk($sformatf("tbl%0d_dat%0d", c, i), 32'(got_d[base+i]), 32'(6'h10 | 6'(i1 + 1)));
               i1++;
            end else begin
               chk($sformatf("tbl%0d_dat%0d", c, i), 32'(got_d[base+i]), 32'(6'(i0 + 3)));
               i0++;
            end
         end
         chk($sformatf("tbl%0d_cnt", c), 32'({count_D0, count_D1}), 32'({5'(tbl[c].n0), 5'(tbl[c].n1)}));
         chk($sformatf("tbl%0d_idle", c), 32'(idle_out), 32'd1);
      end

      // Backpressure: only two pops fit in the two-entry buffer
      do_reset_init(4'd2, 4'd1);
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) load(k[1], seq3[k]);
      base = got_d.size(); pb0 = pops0 + pops1;
      repeat (6) tick();
      chk("bp_pops", 32'(pops0 + pops1 - pb0), 32'd2);
      chk("bp_head", 32'({out_valid, out_data}), 32'({1'b1, 6'b000011}));
      out_ready = 1'b1;
      wait_idle("bp_drain", 200, 1'b0);
      chk("bp_len", 32'(got_d.size() - base), 32'd4);
      for (int i = 0; i < 4 && base + i < got_d.size(); i++)
         chk($sformatf("bp_dat%0d", i), 32'(got_d[base+i]), 32'(seq3[i]));

      // Destination mismatch: forwarded, sticky error, pops stop
      do_reset_init(4'd2, 4'd1);
      base = got_d.size(); pb0 = pops0 + pops1;
      load(1'b0, 6'b010101);
      tick();
      chk("err_not_yet", 32'(error_out), 32'd0);
      tick();
      chk("err_set", 32'({error_out, active_out, idle_out}), 32'b100);
      chk("err_word", 32'({out_valid, out_src, out_data}), 32'({2'b10, 6'b010101}));
      load(1'b0, 6'b000001);
      load(1'b1, 6'b010001);
      repeat (5) tick();
      chk("err_no_pops", 32'(pops0 + pops1 - pb0), 32'd1);
      chk("err_sticky", 32'(error_out), 32'd1);
      chk("err_fwd", 32'(got_d.size() - base), 32'd1);
      if (got_d.size() > base) chk("err_fwd_src", 32'(got_s[base]), 32'd0);
      reset = 1'b1;
      tick();
      chk("err_cleared", 32'(error_out), 32'd0);

      // Reset with a D1 word in flight
      do_reset_init(4'd1, 4'd1);
      base = got_d.size(); pb1 = pops1;
      load(1'b1, 6'b010111);
      load(1'b1, 6'b010110);
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("rst_no_pop", 32'({D0_pop, D1_pop}), 32'd0);
      tick();
      chk("rst_flight_outs", 32'({out_valid, out_data, out_src, count_D0, count_D1, error_out,
                                  active_out, idle_out}), 32'd0);
      repeat (3) tick();
      chk("rst_dropped", 32'(got_d.size() - base), 32'd0);
      chk("rst_one_pop", 32'(pops1 - pb1), 32'd1);

      // Counter wrap
      do_reset_init(4'd2, 4'd1);
      base = got_d.size();
      for (int k = 0; k < 32; k++) load(1'b0, 6'(k % 16));
      repeat (2) tick();
      wait_idle("wrap_drain", 300, 1'b0);
      chk("wrap_len", 32'(got_d.size() - base), 32'd32);
      chk("wrap_cnt", 32'(count_D0), 32'd0);

      // Randomized weights, loads and backpressure against the WRR model
      for (int it = 0; it < 8; it++) begin
         rw0 = 4'($urandom_range(0, 15)); rw1 = 4'($urandom_range(0, 15));
         rn0 = $urandom_range(0, 12);     rn1 = $urandom_range(0, 12);
         do_reset_init(rw0, rw1);
         e0.delete(); e1.delete();
         for (int k = 0; k < rn0; k++) begin
            d = 6'($urandom); d[4] = 1'b0; load(1'b0, d); e0.push_back(d);
         end
         for (int k = 0; k < rn1; k++) begin
            d = 6'($urandom); d[4] = 1'b1; load(1'b1, d); e1.push_back(d);
         end
         wrr_model(rn0, rn1, rw0, rw1);
         base = got_d.size();
         repeat (2) tick();
         wait_idle($sformatf("rnd%0d_drain", it), 600, 1'b1);
         chk($sformatf("rnd%0d_len", it), 32'(got_d.size() - base), 32'(rn0 + rn1));
         nmis = 0; i0 = 0; i1 = 0;
         for (int i = 0; i < exp_src.size() && base + i < got_d.size(); i++) begin
            if (got_s[base+i] !== exp_src[i]) nmis++;
            if (exp_src[i]) begin
               if (got_d[base+i] !== e1[i1]) nmis++;
               i1++;
            end else begin
               if (got_d[base+i] !== e0[i0]) nmis++;
               i0++;
            end
         end
         chk($sformatf("rnd%0d_words", it), 32'(nmis), 32'd0);
         chk($sformatf("rnd%0d_cnt", it), 32'({count_D0, count_D1}), 32'({5'(rn0), 5'(rn1)}));
         chk($sformatf("rnd%0d_err", it), 32'(error_out), 32'd0);
      end

      chk("pop_rules", 32'(bad_pop), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
